clause_streamer: RTL
====================

Name: clause_streamer

Overview:
Host-side transmitter for the solver's clause-load interface, the counterpart of the `load`/`i` receiver in `top`.
- Buffers a host-written sequence of NUM_LIT-bit clause words.
- On `start`, replays the sequence to the solver one word per clock with `load` high, then drops `load`.
- Waits for the solver's `ended`, captures `sat` and `model`, and reports completion or timeout.
- Sits between the host/test controller and `top`; the word format is solver-defined and the streamer treats it as opaque.

Parameters:
NUM_LIT, common::number_literal (30), literal-vector width of every clause word.
DEPTH, 128, buffer capacity in words.
TIMEOUT, 1000000, maximum cycles spent in WAIT before giving up.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous reset, active-low.
clear  in  1  empties the buffer (count := 0); honoured in IDLE and DONE only.
wr_en  in  1  write strobe for wr_data.
wr_data  in  NUM_LIT  clause word to append.
full  out  1  count == DEPTH.
count  out  $clog2(DEPTH+1)  number of buffered words.
start  in  1  begin a streaming run.
busy  out  1  high in STREAM and WAIT.
done  out  1  high in DONE.
timeout  out  1  DONE was reached by timeout rather than by `ended`.
load  out  1  to solver `load`.
i  out  NUM_LIT  to solver `i`.
solver_ended  in  1  from solver `ended`.
solver_sat  in  1  from solver `sat`.
solver_model  in  NUM_LIT  from solver `model`.
sat_o  out  1  captured sat result.
model_o  out  NUM_LIT  captured model.

Behaviour:
- States: IDLE, STREAM, WAIT, DONE.
- Reset (reset==0 at an edge):
  - state := IDLE; count, rd index, and the timeout counter := 0.
  - load, i, busy, done, timeout, sat_o, model_o := 0.
  - Buffer contents are not cleared.
  - Reset wins over every other input, including mid-STREAM; `load` falls on that same edge.
- Writes:
  - Accepted only in IDLE or DONE, and only when !full. The word goes to mem[count] and count increments.
  - wr_en while full, busy, or in the same cycle as clear is dropped; clear has priority.
- IDLE:
  - start with count>0 → STREAM with rd index 0.
  - start with count==0 is ignored.
  - start takes priority over a simultaneous wr_en: the write is dropped.
- STREAM:
  - All outputs are registered.
  - If start is sampled at edge N, word k is driven (load=1, i=mem[k]) from edge N+1+k.
  - At edge N+1+count: load:=0, i:=0, state := WAIT.
  - Words are emitted back-to-back with no gaps and no backpressure.
  - solver_ended is ignored in this state.
- WAIT:
  - load=0, i=0; the timeout counter increments every cycle.
  - solver_ended==1 at an edge: sat_o:=solver_sat, model_o:=solver_model, timeout:=0, state := DONE.
  - If the counter reaches TIMEOUT-1 without ended: sat_o:=0, model_o:=0, timeout:=1, state := DONE.
  - ended in the same cycle as the terminal count: ended wins.
- DONE:
  - Results and done are held.
  - start → STREAM, replaying the same buffer; done, timeout, sat_o, and model_o are cleared on that edge.
  - clear → IDLE with count:=0.
  - clear has priority over start.
- busy = (state==STREAM || state==WAIT); done = (state==DONE).
- The buffer is a plain register array with read address = rd index; no read-latency bubble is permitted.

Decomposition:
- Package common: number_literal (already present). Add CLAUSE_BUF_DEPTH, SOLVER_TIMEOUT, and typedef streamer_state_t {IDLE, STREAM, WAIT, DONE}.
- One sub-module, clause_buffer: a DEPTH×NUM_LIT write-append register array with count/full and an asynchronous read port.
- FSM, counters, and result capture stay in clause_streamer.

Test Plan:
- Reset during STREAM:
  - Stimulus: assert reset at the 3rd streamed word.
  - Required: load=0 at that edge; count=0, state=IDLE, done=0 afterwards.
- Basic stream:
  - Stimulus: write 4 words 30'h2000_0000, 30'h0400_0000, 30'h1000_0000, 30'h0000_0001; pulse start at edge N.
  - Required: load=1 exactly at edges N+1..N+4 carrying those words in order; load=0, i=0 from N+5; busy=1 from N+1.
- Completion:
  - Stimulus: in WAIT, drive solver_ended=1, solver_sat=1, solver_model=30'h0000_0005 for one cycle.
  - Required: next cycle done=1, sat_o=1, model_o=30'h0000_0005, timeout=0; values hold while ended returns to 0.
- Timeout:
  - Stimulus: TIMEOUT=16, no ended.
  - Required: done=1 and timeout=1 exactly 16 cycles after load falls; sat_o=0.
- Full / illegal writes:
  - Stimulus: DEPTH=4, write 5 words; start with count=0; wr_en while busy.
  - Required: count=4 and full=1 with the 5th word dropped; zero-count start leaves state=IDLE; the busy write does not change count.
- Replay and clear:
  - Stimulus: from DONE pulse start; afterwards pulse clear together with start.
  - Required: the identical 4-word sequence is re-streamed and done clears on the start edge; the clear+start cycle yields IDLE with count=0.

Source files
------------

// File: rtl/clause_streamer_pkg.sv
// Package: common
// Shared constants and types for the solver host-side interface.
//   number_literal   - width of one clause / model literal vector
//   CLAUSE_BUF_DEPTH - default clause buffer capacity in words
//   SOLVER_TIMEOUT   - default cycle budget for waiting on the solver
//   streamer_state_t - control states of clause_streamer
package common;

    localparam int number_literal   = 30;
    localparam int CLAUSE_BUF_DEPTH = 128;
    localparam int SOLVER_TIMEOUT   = 1000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } streamer_state_t;

endpackage

// File: rtl/clause_streamer_buffer.sv
// Module: clause_buffer
// Write-append register array holding the clause words of one run.
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous active-low reset (clears count, not contents)
//   clear    in   empties the buffer (count := 0), wins over wr
//   wr       in   append wr_data at mem[count] when not full
//   wr_data  in   clause word
//   rd_addr  in   read index
//   rd_data  out  mem[rd_addr], combinational so streaming has no bubble
//   count    out  number of stored words
//   full     out  count == DEPTH
module clause_buffer
    import common::*;
#(
    parameter int NUM_LIT = number_literal,
    parameter int DEPTH   = CLAUSE_BUF_DEPTH,
    parameter int CW      = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               wr,
    input  logic [NUM_LIT-1:0] wr_data,
    input  logic [CW-1:0]      rd_addr,
    output logic [NUM_LIT-1:0] rd_data,
    output logic [CW-1:0]      count,
    output logic               full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NUM_LIT-1:0] mem [DEPTH];
    logic [CW-1:0]      count_reg;
    logic               wr_ok;

    assign full  = (count_reg == CW'(DEPTH));
    assign wr_ok = reset && wr && !clear && !full;

    // One register per entry; an entry only loads when it is the append slot.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (wr_ok && (count_reg == CW'(gi))) begin
                    mem[gi] <= wr_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (wr_ok) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    // Addresses at or past DEPTH only occur on the final STREAM cycle where
    // the data is not used; return zero there instead of an unknown.
    assign rd_data = (rd_addr < CW'(DEPTH)) ? mem[rd_addr[AW-1:0]] : '0;
    assign count   = count_reg;

endmodule

// File: rtl/clause_streamer.sv
// Module: clause_streamer
// Host-side transmitter for the solver clause-load interface. Buffers clause
// words, replays them with load high one per clock on start, then waits for
// the solver's ended strobe (or a timeout) and captures sat / model.
// Ports:
//   clock, reset            clock and synchronous active-low reset
//   clear, wr_en, wr_data   host buffer control (honoured in IDLE/DONE only)
//   full, count             buffer status
//   start                   begin (or replay) a streaming run
//   busy, done, timeout     run status
//   load, i                 to solver
//   solver_ended/sat/model  from solver
//   sat_o, model_o          captured result
module clause_streamer
    import common::*;
#(
    parameter int NUM_LIT = number_literal,
    parameter int DEPTH   = CLAUSE_BUF_DEPTH,
    parameter int TIMEOUT = SOLVER_TIMEOUT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [NUM_LIT-1:0]         wr_data,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic                       load,
    output logic [NUM_LIT-1:0]         i,
    input  logic                       solver_ended,
    input  logic                       solver_sat,
    input  logic [NUM_LIT-1:0]         solver_model,
    output logic                       sat_o,
    output logic [NUM_LIT-1:0]         model_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    streamer_state_t    state_reg, state_next;
    logic [CW-1:0]      rd_reg, rd_next;
    logic [TW-1:0]      tcnt_reg, tcnt_next;
    logic               load_reg, load_next;
    logic [NUM_LIT-1:0] i_reg, i_next;
    logic               timeout_reg, timeout_next;
    logic               sat_reg, sat_next;
    logic [NUM_LIT-1:0] model_reg, model_next;

    logic               buf_wr;
    logic               buf_clear;
    logic [NUM_LIT-1:0] rd_data;

    clause_buffer #(
        .NUM_LIT (NUM_LIT),
        .DEPTH   (DEPTH),
        .CW      (CW)
    ) u_buffer (
        .clock   (clock),
        .reset   (reset),
        .clear   (buf_clear),
        .wr      (buf_wr),
        .wr_data (wr_data),
        .rd_addr (rd_reg),
        .rd_data (rd_data),
        .count   (count),
        .full    (full)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg   <= IDLE;
            rd_reg      <= '0;
            tcnt_reg    <= '0;
            load_reg    <= 1'b0;
            i_reg       <= '0;
            timeout_reg <= 1'b0;
            sat_reg     <= 1'b0;
            model_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            rd_reg      <= rd_next;
            tcnt_reg    <= tcnt_next;
            load_reg    <= load_next;
            i_reg       <= i_next;
            timeout_reg <= timeout_next;
            sat_reg     <= sat_next;
            model_reg   <= model_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rd_next      = rd_reg;
        tcnt_next    = tcnt_reg;
        load_next    = load_reg;
        i_next       = i_reg;
        timeout_next = timeout_reg;
        sat_next     = sat_reg;
        model_next   = model_reg;
        buf_wr       = 1'b0;
        buf_clear    = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                // Priority: clear, then an accepted start, then a write.
                if (clear) begin
                    buf_clear    = 1'b1;
                    state_next   = IDLE;
                    timeout_next = 1'b0;
                    sat_next     = 1'b0;
                    model_next   = '0;
                end else if (start && (count != '0)) begin
                    state_next   = STREAM;
                    rd_next      = '0;
                    timeout_next = 1'b0;
                    sat_next     = 1'b0;
                    model_next   = '0;
                end else if (wr_en) begin
                    buf_wr = 1'b1;
                end
            end

            STREAM: begin
                if (rd_reg == count) begin
                    load_next  = 1'b0;
                    i_next     = '0;
                    tcnt_next  = '0;
                    state_next = WAIT;
                end else begin
                    load_next = 1'b1;
                    i_next    = rd_data;
                    rd_next   = rd_reg + CW'(1);
                end
            end

            WAIT: begin
                load_next = 1'b0;
                i_next    = '0;
                // ended is tested first so it wins on the terminal count.
                if (solver_ended) begin
                    sat_next     = solver_sat;
                    model_next   = solver_model;
                    timeout_next = 1'b0;
                    state_next   = DONE;
                end else if (tcnt_reg == TW'(TIMEOUT - 1)) begin
                    sat_next     = 1'b0;
                    model_next   = '0;
                    timeout_next = 1'b1;
                    state_next   = DONE;
                end else begin
                    tcnt_next = tcnt_reg + TW'(1);
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign busy    = (state_reg == STREAM) || (state_reg == WAIT);
    assign done    = (state_reg == DONE);
    assign timeout = timeout_reg;
    assign load    = load_reg;
    assign i       = i_reg;
    assign sat_o   = sat_reg;
    assign model_o = model_reg;

endmodule
